outer_in_packer32: RTL

Upstream feeder for the outer input adapter. It takes 32-bit half-words from the external host link and packs each pair into one 64-bit bus word, low half first. If a message ends on an odd half-word, the high half of the last word is padded with zeros. Packed words pass through a small FIFO and are presented on an `o__in` stream that connects directly to the outer input adapter's `o__in*` ports. The block also reports the number of 64-bit words delivered in the current message, which the command issuer uses to size the adapter command.

---
 rtl/outer_in_packer32.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/outer_in_packer32.sv
// outer_in_packer32
// Packs pairs of 32-bit host half-words (low half first) into 64-bit words,
// zero-padding the high half when a message ends on an odd half-word.
// Packed words are queued in a small FIFO feeding the outer input adapter,
// and the number of words popped in the current message is reported.
//
// state  | meaning
// -------+---------------------------------------------------------------
// sEmpty | no half-word held; next accepted half is a low half
// sHalf  | low half held in 'hold'; next accepted half completes the word

module outer_in_packer32 #(
    parameter int Depth = 2,
    parameter int CntW  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     e__in,
    input  logic            e__in_isReady,
    output logic            e__in_canReceive,
    input  logic            e__in_isLast,
    output logic [63:0]     o__in,
    output logic            o__in_isReady,
    input  logic            o__in_canReceive,
    output logic            o__in_isLast,
    output logic [CntW-1:0] wordsOut
);

    localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CountW = $clog2(Depth) + 1;
    localparam logic [CountW-1:0] CountFull = CountW'(Depth);
    localparam logic [CntW-1:0]   WordsMax  = '1;

    typedef enum logic {
        sEmpty = 1'b0,
        sHalf  = 1'b1
    } packState_t;

    packState_t      state;
    packState_t      stateNext;
    logic [31:0]     hold;
    logic [63:0]     memData [Depth];
    logic            memLast [Depth];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CountW-1:0] count;

    logic        inXfer;
    logic        pop;
    logic        push;
    logic        pushLast;
    logic [63:0] pushData;
    logic        holdLoad;

    // Space is judged on the registered count only, so a pop never
    // combinationally frees a slot for the input side.
    assign e__in_canReceive = (count != CountFull);
    assign o__in_isReady    = (count != '0);
    assign inXfer           = e__in_isReady & e__in_canReceive;
    assign pop              = o__in_isReady & o__in_canReceive;
    assign o__in            = memData[rdPtr];
    assign o__in_isLast     = memLast[rdPtr];

    // Packer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= sEmpty;
        end else begin
            state <= stateNext;
        end
    end

    // Packer next-state: a held low half waits for its partner; a last
    // half always returns to sEmpty.
    always_comb begin
        stateNext = state;
        if (inXfer) begin
            case (state)
                sEmpty:  stateNext = e__in_isLast ? sEmpty : sHalf;
                sHalf:   stateNext = sEmpty;
                default: stateNext = sEmpty;
            endcase
        end
    end

    // Packer outputs: decide whether to hold the half or push a full word.
    always_comb begin
        push     = 1'b0;
        pushLast = 1'b0;
        pushData = '0;
        holdLoad = 1'b0;
        if (inXfer) begin
            case (state)
                sEmpty: begin
                    if (e__in_isLast) begin
                        push     = 1'b1;
                        pushLast = 1'b1;
                        pushData = {32'b0, e__in};
                    end else begin
                        holdLoad = 1'b1;
                    end
                end
                sHalf: begin
                    push     = 1'b1;
                    pushLast = e__in_isLast;
                    pushData = {e__in, hold};
                end
                default: begin
                    push = 1'b0;
                end
            endcase
        end
    end

    // Low-half holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (holdLoad) begin
            hold <= e__in;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                memData[i] <= '0;
                memLast[i] <= 1'b0;
            end
        end else if (push) begin
            memData[wrPtr] <= pushData;
            memLast[wrPtr] <= pushLast;
        end
    end

    // FIFO pointers and occupancy; Depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CountW'(1);
                2'b01:   count <= count - CountW'(1);
                default: count <= count;
            endcase
        end
    end

    // Delivered-word counter: saturating count of non-last pops, cleared
    // when the closing word of a message leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wordsOut <= '0;
        end else if (pop) begin
            if (o__in_isLast) begin
                wordsOut <= '0;
            end else if (wordsOut != WordsMax) begin
                wordsOut <= wordsOut + CntW'(1);
            end
        end
    end

endmodule
